// File: rtl/anita3_phi_coincidence_trigger.sv
// rtl/anita3_phi_coincidence_trigger.sv - per-phi L1 stretch, L2 neighbour coincidence and trigger FSM
// Events seen while not ARMED are counted in a saturating dropped counter.
module anita3_phi_coincidence_trigger #(
  parameter int NUM_PHI = 16,
  parameter int WINDOW  = 4,
  parameter int HOLDOFF = 8
) (
  input  logic               clk250_i,
  input  logic               rst_n_i,
  input  logic [NUM_PHI-1:0] V_pol_phi_i,
  input  logic [NUM_PHI-1:0] H_pol_phi_i,
  input  logic               enable_i,
  input  logic               trig_ack_i,
  input  logic               clear_i,
  output logic               trig_valid_o,
  output logic [NUM_PHI-1:0] trig_vphi_o,
  output logic [NUM_PHI-1:0] trig_hphi_o,
  output logic [15:0]        dropped_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PENDING, ST_HOLDOFF} state_t;

  localparam logic [3:0] WIN4  = 4'(WINDOW);
  localparam logic [7:0] HOLD8 = 8'(HOLDOFF);

  logic [3:0]         v_cnt_q [NUM_PHI];
  logic [3:0]         v_cnt_d [NUM_PHI];
  logic [3:0]         h_cnt_q [NUM_PHI];
  logic [3:0]         h_cnt_d [NUM_PHI];
  logic [NUM_PHI-1:0] v_s_q, v_s_d, h_s_q, h_s_d;
  logic [NUM_PHI-1:0] v_l2_q, v_l2_d, h_l2_q, h_l2_d;
  logic [NUM_PHI-1:0] vphi_q, hphi_q;
  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic [15:0]        dropped_q, dropped_d;
  logic               valid_q, busy_q;
  logic               event_w, capture_w;

  // A sector counts only if at least one ring neighbour is also stretched high.
  function automatic logic [NUM_PHI-1:0] l2_of(input logic [NUM_PHI-1:0] s);
    logic [NUM_PHI-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_PHI; j++) begin
      r[j] = s[j] & (s[(j + 1) % NUM_PHI] | s[(j + NUM_PHI - 1) % NUM_PHI]);
    end
    return r;
  endfunction

  always_comb begin
    v_s_d = '0;
    h_s_d = '0;
    for (int j = 0; j < NUM_PHI; j++) begin
      v_cnt_d[j] = V_pol_phi_i[j] ? WIN4 : ((v_cnt_q[j] != 4'd0) ? v_cnt_q[j] - 4'd1 : 4'd0);
      h_cnt_d[j] = H_pol_phi_i[j] ? WIN4 : ((h_cnt_q[j] != 4'd0) ? h_cnt_q[j] - 4'd1 : 4'd0);
      v_s_d[j]   = (v_cnt_d[j] != 4'd0);
      h_s_d[j]   = (h_cnt_d[j] != 4'd0);
    end
    v_l2_d = l2_of(v_s_q);
    h_l2_d = l2_of(h_s_q);
  end

  assign event_w = (|v_l2_q) | (|h_l2_q);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    capture_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (event_w) begin
          state_d   = ST_PENDING;
          capture_w = 1'b1;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (trig_ack_i) begin
          state_d = ST_HOLDOFF;
          hold_d  = HOLD8;
        end
      end
      ST_HOLDOFF: begin
        if (hold_q <= 8'd1) begin
          state_d = enable_i ? ST_ARMED : ST_IDLE;
          hold_d  = 8'd0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dropped_d = dropped_q;
    if (clear_i) begin
      dropped_d = 16'd0;
    end else if (event_w && (state_q != ST_ARMED) && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk250_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < NUM_PHI; j++) begin
        v_cnt_q[j] <= 4'd0;
        h_cnt_q[j] <= 4'd0;
      end
      v_s_q     <= '0;
      h_s_q     <= '0;
      v_l2_q    <= '0;
      h_l2_q    <= '0;
      vphi_q    <= '0;
      hphi_q    <= '0;
      state_q   <= ST_IDLE;
      hold_q    <= 8'd0;
      dropped_q <= 16'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PHI; j++) begin
        v_cnt_q[j] <= v_cnt_d[j];
        h_cnt_q[j] <= h_cnt_d[j];
      end
      v_s_q     <= v_s_d;
      h_s_q     <= h_s_d;
      v_l2_q    <= v_l2_d;
      h_l2_q    <= h_l2_d;
      if (capture_w) begin
        vphi_q <= v_l2_q;
        hphi_q <= h_l2_q;
      end
      state_q   <= state_d;
      hold_q    <= hold_d;
      dropped_q <= dropped_d;
      valid_q   <= (state_d == ST_PENDING);
      busy_q    <= (state_d == ST_PENDING) || (state_d == ST_HOLDOFF);
    end
  end

  assign trig_valid_o = valid_q;
  assign trig_vphi_o  = vphi_q;
  assign trig_hphi_o  = hphi_q;
  assign dropped_o    = dropped_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_anita3_phi_coincidence_trigger.sv
// tb/tb_anita3_phi_coincidence_trigger.sv - directed scenarios plus random stimulus against a reference model
module tb_anita3_phi_coincidence_trigger;
  localparam int NPHI = 16;
  localparam int WIN  = 4;
  localparam int HOLD = 8;
  localparam int S_IDLE = 0, S_ARMED = 1, S_PEND = 2, S_HOLD = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NPHI-1:0] vin = '0, hin = '0;
  logic            en = 1'b0, ack = 1'b0, clr = 1'b0;
  logic            trig_valid_o, busy_o;
  logic [NPHI-1:0] trig_vphi_o, trig_hphi_o;
  logic [15:0]     dropped_o;

  always #2 clk = ~clk;

  anita3_phi_coincidence_trigger #(.NUM_PHI(NPHI), .WINDOW(WIN), .HOLDOFF(HOLD)) dut (
    .clk250_i(clk), .rst_n_i(rst_n), .V_pol_phi_i(vin), .H_pol_phi_i(hin),
    .enable_i(en), .trig_ack_i(ack), .clear_i(clr),
    .trig_valid_o(trig_valid_o), .trig_vphi_o(trig_vphi_o), .trig_hphi_o(trig_hphi_o),
    .dropped_o(dropped_o), .busy_o(busy_o));

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  // reference model state: stretch tracked as "cycle of last 1 seen"
  int              t = 0;
  int              last_v [NPHI];
  int              last_h [NPHI];
  logic [NPHI-1:0] ms_v = '0, ms_h = '0, ml2_v = '0, ml2_h = '0, mtv = '0, mth = '0;
  int              mst = S_IDLE, hold_end = 0, mdrop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [NPHI-1:0] l2f(input logic [NPHI-1:0] s);
    logic [NPHI-1:0] r;
    for (int j = 0; j < NPHI; j++)
      r[j] = s[j] & (s[(j + 1) % NPHI] | s[(j + NPHI - 1) % NPHI]);
    return r;
  endfunction

  task automatic model_edge();
    logic            ev;
    logic [NPHI-1:0] nv, nh;
    int              nst;
    if (!rst_n) begin
      for (int j = 0; j < NPHI; j++) begin
        last_v[j] = -1000000;
        last_h[j] = -1000000;
      end
      ms_v = '0; ms_h = '0; ml2_v = '0; ml2_h = '0; mtv = '0; mth = '0;
      mst = S_IDLE; mdrop = 0;
    end else begin
      ev = ((ml2_v | ml2_h) != '0);
      nst = mst;
      case (mst)
        S_IDLE:  if (en) nst = S_ARMED;
        S_ARMED: if (ev) begin nst = S_PEND; mtv = ml2_v; mth = ml2_h; end
                 else if (!en) nst = S_IDLE;
        S_PEND:  if (ack) begin nst = S_HOLD; hold_end = t + HOLD; end
        default: if (t == hold_end) nst = en ? S_ARMED : S_IDLE;
      endcase
      if (clr) mdrop = 0;
      else if (ev && mst != S_ARMED && mdrop < 65535) mdrop++;
      mst = nst;
      ml2_v = l2f(ms_v);
      ml2_h = l2f(ms_h);
      for (int j = 0; j < NPHI; j++) begin
        if (vin[j]) last_v[j] = t;
        if (hin[j]) last_h[j] = t;
        nv[j] = (t - last_v[j]) < WIN;
        nh[j] = (t - last_h[j]) < WIN;
      end
      ms_v = nv;
      ms_h = nh;
    end
    t++;
  endtask

  task automatic cyc(input logic [NPHI-1:0] v, input logic [NPHI-1:0] h,
                     input logic e, input logic a, input logic c);
    @(negedge clk);
    vin = v; hin = h; en = e; ack = a; clr = c;
    @(posedge clk);
    #1;
    model_edge();
    cmp_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_valid", {31'd0, trig_valid_o}, {31'd0, mst == S_PEND});
      chk("cmp_busy", {31'd0, busy_o}, {31'd0, (mst == S_PEND) || (mst == S_HOLD)});
      chk("cmp_vphi", 32'(trig_vphi_o), 32'(mtv));
      chk("cmp_hphi", 32'(trig_hphi_o), 32'(mth));
      chk("cmp_dropped", 32'(dropped_o), 32'(mdrop));
    end
  end

  initial begin
    logic any;
    // reset and first-trigger latency
    rst_n = 1'b0;
    cyc('0, '0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0);
    rst_n = 1'b1;
    chk("reset_valid", 32'(trig_valid_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_dropped", 32'(dropped_o), 0);
    cyc('0, '0, 1, 0, 0);
    cyc(16'h0018, '0, 1, 0, 0);
    cyc('0, '0, 1, 0, 0);
    chk("lat_e1_valid", 32'(trig_valid_o), 0);
    cyc('0, '0, 1, 0, 0);
    chk("lat_e2_valid", 32'(trig_valid_o), 1);
    chk("first_vphi", 32'(trig_vphi_o), 32'h0018);
    chk("first_hphi", 32'(trig_hphi_o), 32'h0000);
    cyc('0, '0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cyc('0, '0, 1, 0, 0);
      chk("holdoff_busy", 32'(busy_o), (i < 7) ? 1 : 0);
    end
    chk("first_dropped", 32'(dropped_o), 3);

    // wrap-around neighbour 15<->0
    cyc('0, 16'h8000, 1, 0, 0);
    cyc('0, '0, 1, 0, 0);
    cyc('0, '0, 1, 0, 0);
    cyc('0, 16'h0001, 1, 0, 0);
    cyc('0, '0, 1, 0, 0);
    chk("wrap_early_valid", 32'(trig_valid_o), 0);
    cyc('0, '0, 1, 0, 0);
    chk("wrap_valid", 32'(trig_valid_o), 1);
    chk("wrap_hphi", 32'(trig_hphi_o), 32'h8001);
    chk("wrap_vphi", 32'(trig_vphi_o), 32'h0000);
    cyc('0, '0, 1, 1, 0);
    for (int i = 0; i < 12; i++) cyc('0, '0, 1, 0, 0);
    any = 1'b0;
    cyc('0, 16'h8000, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc('0, '0, 1, 0, 0);
    cyc('0, 16'h0001, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc('0, '0, 1, 0, 0);
      any |= trig_valid_o;
    end
    chk("wrap_gap_no_trig", 32'(any), 0);

    // isolated sector never triggers
    any = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc((i < 20) ? 16'h0080 : 16'h0000, '0, 1, 0, 0);
      any |= trig_valid_o;
    end
    chk("isolated_no_trig", 32'(any), 0);
    chk("isolated_dropped", 32'(dropped_o), 3);

    // withheld ack with persistent coincidence
    cyc('0, '0, 1, 0, 1);
    chk("clear_dropped", 32'(dropped_o), 0);
    for (int i = 0; i < 3; i++) cyc(16'h0006, '0, 1, 0, 0);
    chk("pend_valid", 32'(trig_valid_o), 1);
    for (int i = 0; i < 9; i++) begin
      cyc(16'h0006, '0, 1, 0, 0);
      chk("pend_hold_valid", 32'(trig_valid_o), 1);
      chk("pend_hold_vphi", 32'(trig_vphi_o), 32'h0006);
    end
    cyc(16'h0006, '0, 1, 1, 0);
    chk("pend_dropped", 32'(dropped_o), 10);
    for (int i = 0; i < 8; i++) begin
      cyc(16'h0006, '0, 1, 0, 0);
      chk("retrig_busy", 32'(busy_o), (i < 7) ? 1 : 0);
    end
    chk("retrig_dropped", 32'(dropped_o), 18);
    cyc(16'h0006, '0, 1, 0, 0);
    chk("retrig_valid", 32'(trig_valid_o), 1);

    // enable dropped during holdoff, then clear beats increment
    cyc(16'h0006, '0, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(16'h0006, '0, 0, 0, 0);
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(16'h0006, '0, 0, 0, 0);
      any |= trig_valid_o | busy_o;
    end
    chk("disarm_idle", 32'(any), 0);
    cyc(16'h0006, '0, 0, 0, 1);
    chk("clear_priority", 32'(dropped_o), 0);

    // reset during PENDING
    cyc(16'h0006, '0, 1, 0, 0);
    cyc(16'h0006, '0, 1, 0, 0);
    chk("pre_rst_valid", 32'(trig_valid_o), 1);
    rst_n = 1'b0;
    cyc(16'h0006, '0, 1, 0, 0);
    rst_n = 1'b1;
    chk("rst_valid", 32'(trig_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_dropped", 32'(dropped_o), 0);
    chk("rst_vphi", 32'(trig_vphi_o), 0);
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, 0, 0, 0);
      any |= trig_valid_o;
    end
    chk("rst_needs_enable", 32'(any), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NPHI-1:0] rv, rh;
      for (int j = 0; j < NPHI; j++) begin
        rv[j] = ($urandom_range(0, 40) == 0);
        rh[j] = ($urandom_range(0, 40) == 0);
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cyc(rv, rh, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 199) == 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/anita3_phi_coincidence_trigger.md
ANITA3_PHI_COINCIDENCE_TRIGGER -- requirements
Module: anita3_phi_coincidence_trigger

Interface
REQ-001 The block SHALL have the parameter NUM_PHI, default 16, giving the number of phi sectors per polarization.
REQ-002 The block SHALL have the parameter WINDOW, default 4, legal range 1..15, giving the coincidence stretch length in clocks.
REQ-003 The block SHALL have the parameter HOLDOFF, default 8, legal range 1..255, giving the post-trigger dead time in clocks.
REQ-004 The block SHALL have these ports:
  clk250_i  in  1  single clock; all logic rising-edge.
  rst_n_i  in  1  reset; synchronous, active-low.
  V_pol_phi_i  in  NUM_PHI  masked V-pol per-phi L1 from the phi-mapping stage.
  H_pol_phi_i  in  NUM_PHI  masked H-pol per-phi L1.
  enable_i  in  1  arms the trigger.
  trig_ack_i  in  1  consumer acknowledge.
  clear_i  in  1  clears dropped counter.
  trig_valid_o  out  1  trigger pending.
  trig_vphi_o  out  NUM_PHI  captured V-pol L2 pattern.
  trig_hphi_o  out  NUM_PHI  captured H-pol L2 pattern.
  dropped_o  out  16  coincidences lost while busy or disarmed.
  busy_o  out  1  high in PENDING or HOLDOFF.

Function
REQ-005 Per-sector, per-polarization stretch: a 4-bit counter SHALL load WINDOW when the input bit is 1, else decrement if nonzero; the stretched bit SHALL be registered as (counter != 0).
REQ-006 Stretched bits SHALL go high on the edge that samples the input and SHALL stay high for exactly WINDOW cycles after the last sampled 1.
REQ-007 The L2 pattern for sector j SHALL be L2[j] = s[j] & (s[(j+1) mod NUM_PHI] | s[(j+NUM_PHI-1) mod NUM_PHI]), computed separately per polarization, with wrap-around 15<->0.
REQ-008 The L2 patterns SHALL be registered one edge after the stretch registers.
REQ-009 The coincidence event SHALL be the OR of all registered V and H L2 bits.
REQ-010 The FSM SHALL have the states IDLE, ARMED, PENDING and HOLDOFF.
REQ-011 In IDLE, enable_i=1 SHALL cause a transition to ARMED on the next edge.
REQ-012 In ARMED, an event SHALL cause a transition to PENDING and a capture of the registered L2 V/H patterns into trig_vphi_o/trig_hphi_o.
REQ-013 In ARMED, an event SHALL take priority over enable_i=0; with no event and enable_i=0, ARMED SHALL go to IDLE.
REQ-014 trig_valid_o SHALL be high in PENDING, and the captured patterns SHALL stay stable there.
REQ-015 PENDING SHALL be left only on trig_ack_i=1, to HOLDOFF on the next edge; enable_i SHALL be ignored in PENDING.
REQ-016 trig_ack_i SHALL be ignored outside PENDING.
REQ-017 HOLDOFF SHALL last exactly HOLDOFF cycles via an 8-bit down-counter, then go to ARMED if enable_i=1, else to IDLE.
REQ-018 Latency: first input 1 sampled at edge E0 -> stretch at E0 -> L2 at E1 -> trig_valid_o high after E2.
REQ-019 An event occurring in IDLE, PENDING or HOLDOFF, including in the same cycle as the PENDING->HOLDOFF ack, SHALL increment dropped_o by 1 per cycle.
REQ-020 dropped_o SHALL saturate at 0xFFFF.
REQ-021 clear_i SHALL zero dropped_o and SHALL take priority over a same-cycle increment.
REQ-022 Stretch and L2 logic SHALL run in every state, so coincidences spanning the HOLDOFF exit SHALL still trigger.
REQ-023 busy_o SHALL be registered, decoded from the FSM state.

Reset
REQ-024 rst_n_i=0 at an edge SHALL clear all stretch counters, stretch and L2 registers, the holdoff counter and dropped_o, set the FSM to IDLE, and drive all outputs to 0.
REQ-025 Reset asserted mid-PENDING or mid-HOLDOFF SHALL abandon the trigger with no ack required.
REQ-026 After reset is released, the block SHALL require enable_i=1 to rearm.

Verification
REQ-027 Enabled and ARMED; V_pol_phi_i bits 3 and 4 high for 1 cycle at E0 -> trig_valid_o high after E2, trig_vphi_o=0x0018, trig_hphi_o=0x0000.
REQ-028 Wrap-around case: H bit 15 at E0 and H bit 0 at E0+3 (WINDOW=4) -> trig_hphi_o=0x8001; the same pair separated by 4 cycles -> no trigger.
REQ-029 Single isolated V bit 7 held high for 20 cycles -> no trigger and dropped_o stays 0.
REQ-030 Trigger pending, ack withheld 10 cycles while V bits 1 and 2 stay high -> trig_valid_o stays high, patterns unchanged, dropped_o=10 (counting the ack cycle if the event is present); after ack, busy_o is high for HOLDOFF=8 cycles, then a retrigger occurs.
REQ-031 enable_i dropped during HOLDOFF -> IDLE after 8 cycles with no retrigger; clear_i together with an event -> dropped_o=0.
REQ-032 rst_n_i=0 for 1 cycle during PENDING -> next cycle trig_valid_o=0, busy_o=0, dropped_o=0, FSM in IDLE.
